mul_share_sequencer: RTL and testbench

MUL_SHARE_SEQUENCER -- requirements
Module: mul_share_sequencer

---
 rtl/mul_share_sequencer.sv | 121 ++++++++++++
 tb/tb_mul_share_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sequencer.sv
// Shared shift-add multiplier sequencer for two requesters.
// Drives an external A/B/P datapath and holds per-requester products.
module mul_share_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result0,
  output logic [WIDTH-1:0] result1,
  output logic [WIDTH-1:0] data_in,
  output logic             LdA,
  output logic             LdB,
  output logic             LdP,
  output logic             clrP,
  output logic             decB,
  input  logic             eqz,
  input  logic [WIDTH-1:0] Y
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LA   = 3'd1;
  localparam logic [2:0] LB   = 3'd2;
  localparam logic [2:0] CHK  = 3'd3;
  localparam logic [2:0] ADD  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]       state;
  logic             own;
  logic             last;
  logic             pick1;
  logic             busy;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res0;
  logic [WIDTH-1:0] res1;

  // last=1 means requester 0 is preferred on the next tie
  assign pick1 = req1 & (~req0 | ~last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own   <= 1'b0;
      last  <= 1'b1;
      opa   <= '0;
      opb   <= '0;
      res0  <= '0;
      res1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            own   <= pick1;
            last  <= pick1;
            opa   <= pick1 ? a1 : a0;
            opb   <= pick1 ? b1 : b0;
            state <= LA;
          end
        end
        LA:  state <= LB;
        LB:  state <= CHK;
        CHK: begin
          if (eqz) begin
            if (own) res1 <= Y;
            else     res0 <= Y;
            state <= DONE;
          end else begin
            state <= ADD;
          end
        end
        ADD:     state <= CHK;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign gnt0    = busy & ~own;
  assign gnt1    = busy & own;
  assign done0   = (state == DONE) & ~own;
  assign done1   = (state == DONE) & own;
  assign result0 = res0;
  assign result1 = res1;

  always_comb begin
    data_in = '0;
    LdA     = 1'b0;
    LdB     = 1'b0;
    LdP     = 1'b0;
    clrP    = 1'b0;
    decB    = 1'b0;
    case (state)
      LA: begin
        data_in = opa;
        LdA     = 1'b1;
        clrP    = 1'b1;
      end
      LB: begin
        data_in = opb;
        LdB     = 1'b1;
      end
      ADD: begin
        LdP  = 1'b1;
        decB = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_share_sequencer.sv
// Directed bench for mul_share_sequencer with a behavioural A/B/P datapath.
// Cycle 0 is the IDLE cycle in which a request is first seen.
module tb_mul_share_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1;
  logic [W-1:0] result0, result1, data_in;
  logic         LdA, LdB, LdP, clrP, decB;
  logic         eqz;
  logic [W-1:0] Y;

  logic [W-1:0] dp_a, dp_b, dp_p;
  logic [8:0]   ctl;

  int n_cmp = 0;
  int n_bad = 0;
  int overlap = 0;
  bit drop_req = 1'b0;

  always #5 clk = ~clk;

  mul_share_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .result0(result0), .result1(result1),
    .data_in(data_in),
    .LdA(LdA), .LdB(LdB), .LdP(LdP),
    .clrP(clrP), .decB(decB),
    .eqz(eqz), .Y(Y)
  );

  // external datapath the sequencer controls
  always_ff @(posedge clk) begin
    if (LdA) dp_a <= data_in;
    if (LdB) dp_b <= data_in;
    else if (decB) dp_b <= dp_b - 1'b1;
    if (clrP) dp_p <= '0;
    else if (LdP) dp_p <= dp_p + dp_a;
  end
  assign eqz = (dp_b == '0);
  assign Y   = dp_p;
  assign ctl = {gnt0, gnt1, done0, done1, LdA, LdB, LdP, clrP, decB};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // walks cycles from the current IDLE cycle until a done pulse
  task automatic observe(input int maxc, output int la, output int d0,
                         output int d1, output int nldp, output int ng0,
                         output int ng1, output logic [W-1:0] dla);
    la = -1; d0 = -1; d1 = -1; nldp = 0; ng0 = 0; ng1 = 0; dla = '0;
    for (int c = 0; c <= maxc; c++) begin
      if (LdA && la < 0) begin la = c; dla = data_in; end
      if (LdP) nldp++;
      if (gnt0) ng0++;
      if (gnt1) ng1++;
      if (gnt0 && gnt1) overlap++;
      if (drop_req && c == 1) begin
        req0 = 1'b0; req1 = 1'b0;
        a0 = '1; b0 = '1; a1 = '1; b1 = '1;
      end
      if (done0) d0 = c;
      if (done1) d1 = c;
      if (done0 || done1) break;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (ctl !== 9'd0) begin
        n_bad++; $display("FAIL reset_ctl[%0d]: got %b want 0", k, ctl);
      end
      n_cmp++;
      if (data_in !== '0) begin
        n_bad++; $display("FAIL reset_data_in: got %h want 0", data_in);
      end
      tick();
    end
    n_cmp++;
    if (result0 !== '0 || result1 !== '0) begin
      n_bad++;
      $display("FAIL reset_results: got %h/%h want 0/0", result0, result1);
    end
  endtask

  task automatic test_basic();
    int la, d0, d1, nldp, ng0, ng1;
    logic [W-1:0] dla;
    @(negedge clk);
    a0 = 16'd17; b0 = 16'd5; req0 = 1'b1; drop_req = 1'b1;
    #1;
    observe(40, la, d0, d1, nldp, ng0, ng1, dla);
    drop_req = 1'b0;
    n_cmp++;
    if (la !== 1) begin n_bad++; $display("FAIL basic_lda_cycle: got %0d want 1", la); end
    n_cmp++;
    if (dla !== 16'd17) begin n_bad++; $display("FAIL basic_lda_data: got %0d want 17", dla); end
    n_cmp++;
    if (d0 !== 14) begin n_bad++; $display("FAIL basic_done0: got %0d want 14", d0); end
    n_cmp++;
    if (nldp !== 5) begin n_bad++; $display("FAIL basic_ldp: got %0d want 5", nldp); end
    n_cmp++;
    if (ng0 !== 14 || ng1 !== 0) begin
      n_bad++; $display("FAIL basic_gnt: got %0d/%0d want 14/0", ng0, ng1);
    end
    n_cmp++;
    if (result0 !== 16'd85) begin n_bad++; $display("FAIL basic_result0: got %0d want 85", result0); end
  endtask

  task automatic test_zero();
    int la, d0, d1, nldp, ng0, ng1;
    logic [W-1:0] dla;
    @(negedge clk);
    a0 = 16'd9; b0 = 16'd0; req0 = 1'b1; drop_req = 1'b1;
    #1;
    observe(40, la, d0, d1, nldp, ng0, ng1, dla);
    drop_req = 1'b0;
    n_cmp++;
    if (d0 !== 4) begin n_bad++; $display("FAIL zero_done0: got %0d want 4", d0); end
    n_cmp++;
    if (nldp !== 0) begin n_bad++; $display("FAIL zero_ldp: got %0d want 0", nldp); end
    n_cmp++;
    if (result0 !== 16'd0) begin n_bad++; $display("FAIL zero_result0: got %0d want 0", result0); end
  endtask

  task automatic test_back_to_back();
    int la, d0, d1, nldp, ng0, ng1;
    logic [W-1:0] dla;
    int who [4];
    int dc [4];
    int exp_who [4] = '{0, 1, 0, 1};
    do_reset();
    @(negedge clk);
    a0 = 16'd3; b0 = 16'd4; a1 = 16'd7; b1 = 16'd2;
    req0 = 1'b1; req1 = 1'b1;
    #1;
    overlap = 0;
    for (int k = 0; k < 4; k++) begin
      observe(40, la, d0, d1, nldp, ng0, ng1, dla);
      who[k] = (d0 >= 0) ? 0 : (d1 >= 0) ? 1 : -1;
      dc[k]  = (d0 >= 0) ? d0 : d1;
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      else tick();
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (who[k] !== exp_who[k]) begin
        n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, who[k], exp_who[k]);
      end
    end
    n_cmp++;
    if (dc[0] !== 12 || dc[1] !== 8) begin
      n_bad++; $display("FAIL rr_latency: got %0d/%0d want 12/8", dc[0], dc[1]);
    end
    n_cmp++;
    if (result0 !== 16'd12) begin n_bad++; $display("FAIL rr_result0: got %0d want 12", result0); end
    n_cmp++;
    if (result1 !== 16'd14) begin n_bad++; $display("FAIL rr_result1: got %0d want 14", result1); end
    n_cmp++;
    if (overlap !== 0) begin n_bad++; $display("FAIL rr_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_wrap();
    int la, d0, d1, nldp, ng0, ng1;
    logic [W-1:0] dla;
    @(negedge clk);
    a0 = 16'h8000; b0 = 16'd3; req0 = 1'b1; drop_req = 1'b1;
    #1;
    observe(40, la, d0, d1, nldp, ng0, ng1, dla);
    drop_req = 1'b0;
    n_cmp++;
    if (result0 !== 16'h8000) begin n_bad++; $display("FAIL wrap_result0: got %h want 8000", result0); end
    n_cmp++;
    if (result1 !== 16'd14) begin n_bad++; $display("FAIL wrap_result1: got %0d want 14", result1); end
    n_cmp++;
    if (d0 !== 10 || d1 !== -1) begin
      n_bad++; $display("FAIL wrap_done: got %0d/%0d want 10/-1", d0, d1);
    end
  endtask

  task automatic test_reset_mid();
    int la, d0, d1, nldp, ng0, ng1;
    int c;
    logic [W-1:0] dla;
    @(negedge clk);
    a0 = 16'd5; b0 = 16'd10; req0 = 1'b1;
    #1;
    tick();
    req0 = 1'b0;
    c = 0;
    while (!LdP && c < 30) begin tick(); c++; end
    n_cmp++;
    if (LdP !== 1'b1) begin n_bad++; $display("FAIL rstmid_add_seen: got %b want 1", LdP); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (ctl !== 9'd0 || data_in !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got %b/%h want 0/0", ctl, data_in);
    end
    n_cmp++;
    if (result0 !== '0 || result1 !== '0) begin
      n_bad++; $display("FAIL rstmid_results: got %h/%h want 0/0", result0, result1);
    end
    @(negedge clk);
    a1 = 16'd6; b1 = 16'd6; req1 = 1'b1; drop_req = 1'b1;
    #1;
    observe(40, la, d0, d1, nldp, ng0, ng1, dla);
    drop_req = 1'b0;
    n_cmp++;
    if (d1 !== 16) begin n_bad++; $display("FAIL rstmid_done1: got %0d want 16", d1); end
    n_cmp++;
    if (result1 !== 16'd36) begin n_bad++; $display("FAIL rstmid_result1: got %0d want 36", result1); end
    n_cmp++;
    if (result0 !== 16'd0) begin n_bad++; $display("FAIL rstmid_result0: got %0d want 0", result0); end
  endtask

  task automatic test_drop();
    int la, d0, d1, nldp, ng0, ng1;
    int extra;
    logic [W-1:0] dla;
    @(negedge clk);
    a1 = 16'd4; b1 = 16'd3; req1 = 1'b1; drop_req = 1'b1;
    #1;
    observe(40, la, d0, d1, nldp, ng0, ng1, dla);
    drop_req = 1'b0;
    n_cmp++;
    if (d1 !== 10) begin n_bad++; $display("FAIL drop_done1: got %0d want 10", d1); end
    n_cmp++;
    if (result1 !== 16'd12) begin n_bad++; $display("FAIL drop_result1: got %0d want 12", result1); end
    extra = 0;
    repeat (20) begin
      tick();
      if (done0 || done1 || gnt0 || gnt1) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL drop_extra_activity: got %0d want 0", extra); end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
